// File: rtl/alu_multicycle.sv
// rtl/alu_multicycle.sv - multi-cycle EX-stage ALU with registered outputs and start/done handshake
//
// Single-cycle ops (add/sub/and/or/slt) complete one cycle after start.
// mul runs a WIDTH-iteration shift-add loop. With ALU_DIV_EN defined, divu/remu
// run a WIDTH-iteration restoring divider. Without it, no divider logic exists
// and those codes are reported as illegal.
//
// Ports:
//   clk     in   rising-edge clock
//   reset   in   synchronous, active-high reset
//   start   in   request, sampled only while busy=0
//   ctl     in   [3:0] operation code, captured with start
//   op1     in   [WIDTH-1:0] operand 1, captured with start
//   op2     in   [WIDTH-1:0] operand 2, captured with start
//   busy    out  iterative operation in progress
//   done    out  one-cycle pulse, result/zero valid
//   result  out  [WIDTH-1:0] registered result, held until next done
//   zero    out  registered, 1 iff the most recently written result == 0
//   illegal out  one-cycle pulse with done for an unsupported ctl
//
// Optional feature macro: ALU_DIV_EN

module alu_multicycle #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       ctl,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal
);

    localparam logic [3:0] CTL_AND  = 4'b0000;
    localparam logic [3:0] CTL_OR   = 4'b0001;
    localparam logic [3:0] CTL_ADD  = 4'b0010;
    localparam logic [3:0] CTL_MUL  = 4'b0011;
`ifdef ALU_DIV_EN
    localparam logic [3:0] CTL_DIVU = 4'b0100;
    localparam logic [3:0] CTL_REMU = 4'b0101;
`endif
    localparam logic [3:0] CTL_SUB  = 4'b0110;
    localparam logic [3:0] CTL_SLT  = 4'b0111;

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Shared iteration registers.
    //   mul: acc = running product, opa = shifted multiplicand, opb = shifted multiplier
    //   div: acc = partial remainder, opa = divisor, opb = dividend shifting into quotient
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;

    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             done_q, done_d;
    logic             illegal_q, illegal_d;

    logic             last_iter;
    logic             is_single;
    logic             is_mul;
    logic [WIDTH-1:0] alu_out;
    logic [WIDTH-1:0] mul_acc_next;

`ifdef ALU_DIV_EN
    logic             is_div;
    logic [3:0]       ctl_q, ctl_d;
    logic [WIDTH:0]   rem_shift;
    logic             rem_ge;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;
`endif

    assign last_iter = (cnt_q == LAST_ITER);

    // Opcode decode
    always_comb begin
        is_single = 1'b0;
        is_mul    = 1'b0;
        case (ctl)
            CTL_ADD, CTL_SUB, CTL_AND, CTL_OR, CTL_SLT: is_single = 1'b1;
            CTL_MUL:                                    is_mul    = 1'b1;
            default: ;
        endcase
    end

`ifdef ALU_DIV_EN
    assign is_div = (ctl == CTL_DIVU) || (ctl == CTL_REMU);
`endif

    // Single-cycle datapath
    always_comb begin
        alu_out = '0;
        case (ctl)
            CTL_ADD: alu_out = op1 + op2;
            CTL_SUB: alu_out = op1 - op2;
            CTL_AND: alu_out = op1 & op2;
            CTL_OR:  alu_out = op1 | op2;
            CTL_SLT: alu_out = {{(WIDTH-1){1'b0}}, ($signed(op1) < $signed(op2))};
            default: alu_out = '0;
        endcase
    end

    // One shift-add step: add the multiplicand when the current multiplier bit is set.
    assign mul_acc_next = acc_q + (opb_q[0] ? opa_q : '0);

`ifdef ALU_DIV_EN
    // One restoring step: bring the next dividend bit into the remainder and
    // subtract the divisor if it fits. The remainder stays below the divisor
    // (or, for a zero divisor, holds only the bits shifted in so far), so the
    // wrapped WIDTH-bit difference is exact whenever it is kept.
    assign rem_shift = {acc_q, opb_q[WIDTH-1]};
    assign rem_ge    = (rem_shift >= {1'b0, opa_q});
    assign rem_next  = rem_ge ? (rem_shift[WIDTH-1:0] - opa_q) : rem_shift[WIDTH-1:0];
    assign quo_next  = {opb_q[WIDTH-2:0], rem_ge};
`endif

    // FSM: state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (is_mul) begin
                        state_d = S_MUL;
                    end
`ifdef ALU_DIV_EN
                    if (is_div) begin
                        state_d = S_DIV;
                    end
`endif
                end
            end
            S_MUL:   if (last_iter) state_d = S_IDLE;
            S_DIV:   if (last_iter) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM: outputs and datapath next-state
    always_comb begin
        busy      = (state_q != S_IDLE);
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        result_d  = result_q;
        zero_d    = zero_q;
        done_d    = 1'b0;
        illegal_d = 1'b0;
`ifdef ALU_DIV_EN
        ctl_d     = ctl_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (is_single) begin
                        result_d = alu_out;
                        zero_d   = (alu_out == '0);
                        done_d   = 1'b1;
                    end else if (is_mul) begin
                        cnt_d = '0;
                        acc_d = '0;
                        opa_d = op1;
                        opb_d = op2;
`ifdef ALU_DIV_EN
                    end else if (is_div) begin
                        cnt_d = '0;
                        acc_d = '0;
                        opa_d = op2;
                        opb_d = op1;
                        ctl_d = ctl;
`endif
                    end else begin
                        // Unsupported code: report it, leave result/zero untouched.
                        done_d    = 1'b1;
                        illegal_d = 1'b1;
                    end
                end
            end
            S_MUL: begin
                cnt_d = cnt_q + CW'(1);
                acc_d = mul_acc_next;
                opa_d = opa_q << 1;
                opb_d = opb_q >> 1;
                if (last_iter) begin
                    result_d = mul_acc_next;
                    zero_d   = (mul_acc_next == '0);
                    done_d   = 1'b1;
                end
            end
`ifdef ALU_DIV_EN
            S_DIV: begin
                cnt_d = cnt_q + CW'(1);
                acc_d = rem_next;
                opb_d = quo_next;
                if (last_iter) begin
                    result_d = (ctl_q == CTL_DIVU) ? quo_next : rem_next;
                    zero_d   = ((ctl_q == CTL_DIVU) ? quo_next : rem_next) == '0;
                    done_d   = 1'b1;
                end
            end
`endif
            default: ;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            acc_q     <= '0;
            opa_q     <= '0;
            opb_q     <= '0;
            result_q  <= '0;
            zero_q    <= 1'b1;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
`ifdef ALU_DIV_EN
            ctl_q     <= '0;
`endif
        end else begin
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            done_q    <= done_d;
            illegal_q <= illegal_d;
`ifdef ALU_DIV_EN
            ctl_q     <= ctl_d;
`endif
        end
    end

    assign done    = done_q;
    assign result  = result_q;
    assign zero    = zero_q;
    assign illegal = illegal_q;

endmodule
